// File: rtl/fetch_controller_pkg.sv
// Shared types and sizing helpers for the fetch sequencing controller.
package fetch_controller_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StBoot,
    StRun,
    StWait,
    StPend
  } fetch_state_e;

  // Width of the wait-state counter; at least one bit so IMEM_WAIT=0 still elaborates.
  function automatic int unsigned wait_cnt_w(input int unsigned imem_wait);
    int unsigned w;
    w = $clog2(imem_wait + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Loadable down-counter with enable; tc_o flags the count that returns the FSM to RUN.
module fetch_wait_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: PC freeze, IF/ID flush, branch redirect and deferred branch replay.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned IMEM_WAIT   = 0,
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hazard_in,
  input  logic                   mem_freeze_in,
  input  logic                   branch_taken_in,
  input  logic [WORD_LENGTH-1:0] branch_addr_in,
  output logic                   freeze_out,
  output logic                   flush_out,
  output logic                   branch_taken_out,
  output logic [WORD_LENGTH-1:0] branch_addr_out,
  output logic                   fetch_valid_out
);

  localparam int unsigned WAIT_CNT_W = wait_cnt_w(IMEM_WAIT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(IMEM_WAIT);
  localparam bit HAS_WAIT = (IMEM_WAIT > 0);

  fetch_state_e           state_q;
  fetch_state_e           state_d;
  logic [WORD_LENGTH-1:0] pend_addr_q;
  logic                   pend_load;
  logic                   cnt_load;
  logic                   cnt_en;
  logic                   cnt_tc;
  logic                   advance;

  fetch_wait_counter #(
    .WIDTH (WAIT_CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    freeze_out       = 1'b0;
    flush_out        = 1'b0;
    branch_taken_out = 1'b0;
    branch_addr_out  = '0;
    fetch_valid_out  = 1'b0;
    state_d          = state_q;
    pend_load        = 1'b0;
    cnt_load         = 1'b0;
    cnt_en           = 1'b0;
    advance          = 1'b0;

    unique case (state_q)
      StBoot: begin
        freeze_out = 1'b1;
        flush_out  = 1'b1;
        state_d    = StRun;
      end

      StRun: begin
        if (mem_freeze_in) begin
          freeze_out = 1'b1;
          if (branch_taken_in) begin
            pend_load = 1'b1;
            state_d   = StPend;
          end
        end else if (branch_taken_in) begin
          // A taken branch overrides a hazard: the stalled ID instruction is flushed anyway.
          branch_taken_out = 1'b1;
          branch_addr_out  = branch_addr_in;
          flush_out        = 1'b1;
          advance          = 1'b1;
        end else if (hazard_in) begin
          freeze_out = 1'b1;
        end else begin
          fetch_valid_out = 1'b1;
          advance         = 1'b1;
        end
      end

      StWait: begin
        freeze_out = 1'b1;
        if (!mem_freeze_in) begin
          if (branch_taken_in) begin
            freeze_out       = 1'b0;
            branch_taken_out = 1'b1;
            branch_addr_out  = branch_addr_in;
            flush_out        = 1'b1;
            advance          = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
              state_d = StRun;
            end
          end
        end else if (branch_taken_in) begin
          pend_load = 1'b1;
          state_d   = StPend;
        end
      end

      StPend: begin
        // The EXE branch is held while frozen, so a still-high branch_taken_in is the same one.
        freeze_out = mem_freeze_in;
        if (!mem_freeze_in) begin
          branch_taken_out = 1'b1;
          branch_addr_out  = pend_addr_q;
          flush_out        = 1'b1;
          advance          = 1'b1;
        end
      end

      default: begin
        freeze_out = 1'b1;
        flush_out  = 1'b1;
        state_d    = StBoot;
      end
    endcase

    if (advance) begin
      if (HAS_WAIT) begin
        cnt_load = 1'b1;
        state_d  = StWait;
      end else begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StBoot;
      pend_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (pend_load) begin
        pend_addr_q <= branch_addr_in;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with IMEM_WAIT = 0, 2 and 3 instances sharing stimulus.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        mem_freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;

  logic [2:0]  frz_o;
  logic [2:0]  fl_o;
  logic [2:0]  bt_o;
  logic [2:0]  fv_o;
  logic [31:0] ba_o [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    int          id;
    string       name;
    logic        frz;
    logic        fl;
    logic        bt;
    logic [31:0] ba;
    logic        fv;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_controller #(.IMEM_WAIT(0), .WORD_LENGTH(32)) u_dut0 (
    .clk (clk), .rst (rst), .hazard_in (hazard), .mem_freeze_in (mem_freeze),
    .branch_taken_in (branch_taken), .branch_addr_in (branch_addr),
    .freeze_out (frz_o[0]), .flush_out (fl_o[0]), .branch_taken_out (bt_o[0]),
    .branch_addr_out (ba_o[0]), .fetch_valid_out (fv_o[0])
  );

  fetch_controller #(.IMEM_WAIT(2), .WORD_LENGTH(32)) u_dut2 (
    .clk (clk), .rst (rst), .hazard_in (hazard), .mem_freeze_in (mem_freeze),
    .branch_taken_in (branch_taken), .branch_addr_in (branch_addr),
    .freeze_out (frz_o[1]), .flush_out (fl_o[1]), .branch_taken_out (bt_o[1]),
    .branch_addr_out (ba_o[1]), .fetch_valid_out (fv_o[1])
  );

  fetch_controller #(.IMEM_WAIT(3), .WORD_LENGTH(32)) u_dut3 (
    .clk (clk), .rst (rst), .hazard_in (hazard), .mem_freeze_in (mem_freeze),
    .branch_taken_in (branch_taken), .branch_addr_in (branch_addr),
    .freeze_out (frz_o[2]), .flush_out (fl_o[2]), .branch_taken_out (bt_o[2]),
    .branch_addr_out (ba_o[2]), .fetch_valid_out (fv_o[2])
  );

  // Monitor: at mid-cycle, compare every expectation stamped with the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s dut%0d stale entry cyc=%0d now=%0d", e.name, e.id, e.cyc, cyc);
      end else if ({frz_o[e.id], fl_o[e.id], bt_o[e.id], fv_o[e.id]} !==
                   {e.frz, e.fl, e.bt, e.fv} || ba_o[e.id] !== e.ba) begin
        bad++;
        $display("FAIL %s dut%0d cyc=%0d got frz/fl/bt/fv=%b addr=%h want %b addr=%h",
                 e.name, e.id, cyc, {frz_o[e.id], fl_o[e.id], bt_o[e.id], fv_o[e.id]},
                 ba_o[e.id], {e.frz, e.fl, e.bt, e.fv}, e.ba);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hz, input logic mf, input logic bt, input logic [31:0] ba);
    hazard       = hz;
    mem_freeze   = mf;
    branch_taken = bt;
    branch_addr  = ba;
  endtask

  task automatic expect_out(input int id, input string name, input logic frz, input logic fl,
                            input logic bt, input logic [31:0] ba, input logic fv);
    exp_t e;
    e.cyc = cyc; e.id = id; e.name = name;
    e.frz = frz; e.fl = fl; e.bt = bt; e.ba = ba; e.fv = fv;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 32'h0);
    tick();
    for (int id = 0; id < 3; id++) expect_out(id, "in_reset", 1, 1, 0, 32'h0, 0);
    tick();
    rst = 1'b0;
    for (int id = 0; id < 3; id++) expect_out(id, "boot", 1, 1, 0, 32'h0, 0);
    tick();

    // Free-running: period 1, 3 and 4 cycles for IMEM_WAIT 0, 2, 3.
    for (int i = 0; i < 8; i++) begin
      expect_out(0, "free_w0", 0, 0, 0, 32'h0, 1);
      expect_out(1, "free_w2", (i % 3) != 0, 0, 0, 32'h0, (i % 3) == 0);
      expect_out(2, "free_w3", (i % 4) != 0, 0, 0, 32'h0, (i % 4) == 0);
      tick();
    end

    // Hazard together with a branch: the branch wins.
    drive(1, 0, 1, 32'h40);
    expect_out(0, "hz_and_br", 0, 1, 1, 32'h40, 0);
    tick();
    drive(1, 0, 0, 32'h0);
    expect_out(0, "hazard", 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 0, 32'h0);
    expect_out(0, "post_hazard", 0, 0, 0, 32'h0, 1);
    tick();

    // Branch during memory freeze is stored and replayed when the freeze lifts.
    drive(0, 1, 1, 32'h100);
    expect_out(0, "mf_capture", 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 1, 1, 32'h100);
    expect_out(0, "pend_hold1", 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 1, 0, 32'h0);
    expect_out(0, "pend_hold2", 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 0, 32'h0);
    expect_out(0, "pend_replay", 0, 1, 1, 32'h100, 0);
    tick();
    expect_out(0, "pend_after", 0, 0, 0, 32'h0, 1);
    tick();

    // IMEM_WAIT=3: redirect in the second WAIT cycle reloads the wait count.
    do_reset();
    expect_out(2, "w_run", 0, 0, 0, 32'h0, 1);
    tick();
    expect_out(2, "w_wait1", 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 1, 32'h20);
    expect_out(2, "w_redirect", 0, 1, 1, 32'h20, 0);
    tick();
    drive(0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      expect_out(2, "w_reload", 1, 0, 0, 32'h0, 0);
      tick();
    end
    expect_out(2, "w_back_run", 0, 0, 0, 32'h0, 1);
    tick();
    drive(0, 1, 1, 32'h80);
    expect_out(2, "w_mf_capture", 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 0, 32'h0);
    expect_out(2, "w_pend_replay", 0, 1, 1, 32'h80, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_out(2, "w_after_pend", 1, 0, 0, 32'h0, 0);
      tick();
    end
    expect_out(2, "w_back_run2", 0, 0, 0, 32'h0, 1);
    tick();
    // Memory freeze inside WAIT holds the count.
    drive(0, 1, 0, 32'h0);
    expect_out(2, "w_mf_hold", 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      expect_out(2, "w_count", 1, 0, 0, 32'h0, 0);
      tick();
    end
    expect_out(2, "w_back_run3", 0, 0, 0, 32'h0, 1);
    tick();

    // Reset while a branch is pending drops it.
    do_reset();
    drive(0, 1, 1, 32'h300);
    expect_out(0, "p_capture", 1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 1, 0, 32'h0);
    expect_out(0, "p_hold", 1, 0, 0, 32'h0, 0);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 32'h0);
    expect_out(0, "p_async_rst", 1, 1, 0, 32'h0, 0);
    tick();
    rst = 1'b0;
    expect_out(0, "p_boot", 1, 1, 0, 32'h0, 0);
    tick();
    expect_out(0, "p_no_replay", 0, 0, 0, 32'h0, 1);
    tick();
    tick();

    if (sb.size() != 0) begin
      bad += sb.size();
      $display("FAIL scoreboard_drain left=%0d", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
